// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard/sequencer block of the 5-stage RV32 core:
// forward-select encodings, sequencer states and the bypass-select helper.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MDU_WAIT = 1'b1
    } state_e;

    // MEM stage has priority over WB; x0 is never bypassed.
    function automatic fwd_sel_e fwd_select(
        input logic       wr_m,
        input logic [4:0] rd_m,
        input logic       wr_w,
        input logic [4:0] rd_w,
        input logic [4:0] rs
    );
        fwd_sel_e sel;
        sel = FWD_RF;
        if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) sel = FWD_WB;
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) sel = FWD_MEM;
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard unit signal bundle.
//   master : pipeline side (drives register indices / status, receives controls)
//   slave  : hazard_ctrl side
// Inputs to the hazard unit: RS1_D/RS2_D, RS1_E/RS2_E/RD_E, MemRead_E, mdu_op_E,
// PCSrc_E, RD_M/RegWrite_M, RD_W/RegWrite_W, imem_ready, mdu_done.
// Outputs: stall/flush controls, forward selects, mdu_start/mdu_err, profiling counters.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       RS1_D;
    logic [4:0]       RS2_D;
    logic [4:0]       RS1_E;
    logic [4:0]       RS2_E;
    logic [4:0]       RD_E;
    logic             MemRead_E;
    logic             mdu_op_E;
    logic             PCSrc_E;
    logic [4:0]       RD_M;
    logic             RegWrite_M;
    logic [4:0]       RD_W;
    logic             RegWrite_W;
    logic             imem_ready;
    logic             mdu_done;

    logic             Stall_F;
    logic             Stall_D;
    logic             Flush_D;
    logic             Stall_E;
    logic             Flush_E;
    logic             Flush_M;
    logic [1:0]       ForwardA_E;
    logic [1:0]       ForwardB_E;
    logic             mdu_start;
    logic             mdu_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output RS1_D, RS2_D, RS1_E, RS2_E, RD_E, MemRead_E, mdu_op_E, PCSrc_E,
               RD_M, RegWrite_M, RD_W, RegWrite_W, imem_ready, mdu_done,
        input  Stall_F, Stall_D, Flush_D, Stall_E, Flush_E, Flush_M,
               ForwardA_E, ForwardB_E, mdu_start, mdu_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, MemRead_E, mdu_op_E, PCSrc_E,
               RD_M, RegWrite_M, RD_W, RegWrite_W, imem_ready, mdu_done,
        output Stall_F, Stall_D, Flush_D, Stall_E, Flush_E, Flush_M,
               ForwardA_E, ForwardB_E, mdu_start, mdu_err, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the profiling counters.
//   clk, rst_n : clock, asynchronous active-low reset (clears to 0)
//   en         : increment this cycle
//   q          : count value; holds at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en && (q_q != '1)) q_d = q_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32 core: stall/flush/forward controls for
// IF/ID/EX/MEM covering load-use, branch/jump redirect, fetch wait and multi-cycle
// MDU ops, plus saturating stall/flush profiling counters.
//   clk, rst_n : core clock, asynchronous active-low reset
//   hz         : hazard_ctrl_if slave port (all pipeline inputs and control outputs)
// While rst_n is low every combinational output is held at 0.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MDU_TIMEOUT = 64
) (
    input logic        clk,
    input logic        rst_n,
    hazard_ctrl_if.slave hz
);

    localparam int WAIT_W = $clog2(MDU_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mdu_start_q, mdu_start_d;
    logic              mdu_err_q, mdu_err_d;

    logic     lu;
    logic     stall_f, stall_d, flush_d, stall_e, flush_e, flush_m;
    logic     redirect;
    fwd_sel_e fwd_a, fwd_b;

    assign fwd_a = fwd_select(hz.RegWrite_M, hz.RD_M, hz.RegWrite_W, hz.RD_W, hz.RS1_E);
    assign fwd_b = fwd_select(hz.RegWrite_M, hz.RD_M, hz.RegWrite_W, hz.RD_W, hz.RS2_E);

    // rs2 is compared for every format; a false stall only costs a cycle.
    assign lu = hz.MemRead_E && (hz.RD_E != 5'd0) &&
                ((hz.RD_E == hz.RS1_D) || (hz.RD_E == hz.RS2_D));

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mdu_start_d = 1'b0;
        mdu_err_d   = mdu_err_q;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        flush_d     = 1'b0;
        stall_e     = 1'b0;
        flush_e     = 1'b0;
        flush_m     = 1'b0;
        redirect    = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (hz.PCSrc_E) begin
                    flush_d  = 1'b1;
                    flush_e  = 1'b1;
                    redirect = 1'b1;
                end else if (hz.mdu_op_E) begin
                    stall_f     = 1'b1;
                    stall_d     = 1'b1;
                    stall_e     = 1'b1;
                    flush_m     = 1'b1;
                    mdu_start_d = 1'b1;
                    wait_cnt_d  = '0;
                    state_d     = ST_MDU_WAIT;
                end else if (lu) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end else if (!hz.imem_ready) begin
                    stall_f = 1'b1;
                    flush_d = 1'b1;
                end
            end
            ST_MDU_WAIT: begin
                // Up to MDU_TIMEOUT held cycles, then a release cycle that flags the abort.
                if (hz.mdu_done) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q == WAIT_W'(MDU_TIMEOUT)) begin
                    mdu_err_d = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    stall_f    = 1'b1;
                    stall_d    = 1'b1;
                    stall_e    = 1'b1;
                    flush_m    = 1'b1;
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            mdu_start_q <= 1'b0;
            mdu_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mdu_start_q <= mdu_start_d;
            mdu_err_q   <= mdu_err_d;
        end
    end

    assign hz.Stall_F    = rst_n & stall_f;
    assign hz.Stall_D    = rst_n & stall_d;
    assign hz.Flush_D    = rst_n & flush_d;
    assign hz.Stall_E    = rst_n & stall_e;
    assign hz.Flush_E    = rst_n & flush_e;
    assign hz.Flush_M    = rst_n & flush_m;
    assign hz.ForwardA_E = rst_n ? fwd_a : FWD_RF;
    assign hz.ForwardB_E = rst_n ? fwd_b : FWD_RF;
    assign hz.mdu_start  = mdu_start_q;
    assign hz.mdu_err    = mdu_err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stall_f),
        .q     (hz.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (redirect),
        .q     (hz.flush_cnt)
    );

endmodule
